// File: rtl/mem_multi_bank_pkg.sv
// Shared types and limits for the multi-bank memory with bulk clear.
package mem_multi_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_state_t;

    // Largest supported read latency; larger OUTPUT_DELAY values are clamped.
    localparam int MAX_OUTPUT_DELAY = 3;

endpackage

// File: rtl/mem_multi_bank_clear_if.sv
// Clear handshake, write port and read port of mem_multi_bank_clear.
interface mem_multi_bank_clear_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int NUM_BANKS  = 4
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BANK_WIDTH = $clog2(NUM_BANKS);

    logic                  clear_req;
    logic [NUM_BANKS-1:0]  clear_mask;
    logic                  clear_ready;
    logic [NUM_BANKS-1:0]  clear_busy;
    logic                  clear_done_pulse;

    logic                  wea;
    logic [BANK_WIDTH-1:0] banka;
    logic [ADDR_WIDTH-1:0] addra;
    logic [DATA_WIDTH-1:0] dia;
    logic                  wr_ready;

    logic                  reb;
    logic [BANK_WIDTH-1:0] bankb;
    logic [ADDR_WIDTH-1:0] addrb;
    logic [DATA_WIDTH-1:0] dob;
    logic                  dob_valid;

    modport master (
        output clear_req, clear_mask, wea, banka, addra, dia, reb, bankb, addrb,
        input  clear_ready, clear_busy, clear_done_pulse, wr_ready, dob, dob_valid
    );

    modport slave (
        input  clear_req, clear_mask, wea, banka, addra, dia, reb, bankb, addrb,
        output clear_ready, clear_busy, clear_done_pulse, wr_ready, dob, dob_valid
    );

endinterface

// File: rtl/mem_clear_sequencer.sv
// IDLE/CLEAR state machine that sweeps a cursor over every address of the masked banks.
module mem_clear_sequencer
    import mem_multi_bank_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_req,
    input  logic [NUM_BANKS-1:0]  clear_mask,
    output logic                  clear_ready,
    output logic [NUM_BANKS-1:0]  clear_busy,
    output logic                  clear_done_pulse,
    output logic [ADDR_WIDTH-1:0] clear_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    clear_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] cursor, cursor_next;
    logic [NUM_BANKS-1:0]  mask_q, mask_next;
    logic                  done_q, done_next;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cursor <= '0;
            mask_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            cursor <= cursor_next;
            mask_q <= mask_next;
            done_q <= done_next;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        cursor_next = cursor;
        mask_next   = mask_q;
        done_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    if (|clear_mask) begin
                        state_next  = CLEAR;
                        mask_next   = clear_mask;
                        cursor_next = '0;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (cursor == LAST_ADDR) begin
                    state_next  = IDLE;
                    cursor_next = '0;
                    done_next   = 1'b1;
                end else begin
                    cursor_next = cursor + ADDR_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign clear_ready      = (state == IDLE);
    assign clear_busy       = (state == CLEAR) ? mask_q : '0;
    assign clear_done_pulse = done_q;
    assign clear_addr       = cursor;

endmodule

// File: rtl/mem_simple_dual_port.sv
// One write port, one registered read port; read-during-write returns the old word.
module mem_simple_dual_port #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   rd_data <= '0;
        else if (re) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mem_simple_dual_port_async_read.sv
// One synchronous write port, one combinational read port.
module mem_simple_dual_port_async_read #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mem_multi_bank_clear.sv
// Banked dual-port memory with a background per-bank clear engine.
// Define MEM_CLEAR_READ_MASK_EN to return DEFAULT_VALUE for reads of banks under clear.
module mem_multi_bank_clear
    import mem_multi_bank_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    DEPTH         = 16,
    parameter int                    NUM_BANKS     = 4,
    parameter int                    OUTPUT_DELAY  = 1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input logic                 clk,
    input logic                 reset,
    mem_multi_bank_clear_if.slave bus
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BANK_WIDTH = $clog2(NUM_BANKS);
    localparam int READ_DELAY = (OUTPUT_DELAY > MAX_OUTPUT_DELAY) ? MAX_OUTPUT_DELAY : OUTPUT_DELAY;

    logic [NUM_BANKS-1:0]  clear_busy;
    logic [ADDR_WIDTH-1:0] clear_addr;
    logic [DATA_WIDTH-1:0] rd_data [NUM_BANKS];
    logic                  read_masked;

    mem_clear_sequencer #(
        .DEPTH      (DEPTH),
        .NUM_BANKS  (NUM_BANKS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sequencer (
        .clk              (clk),
        .reset            (reset),
        .clear_req        (bus.clear_req),
        .clear_mask       (bus.clear_mask),
        .clear_ready      (bus.clear_ready),
        .clear_busy       (clear_busy),
        .clear_done_pulse (bus.clear_done_pulse),
        .clear_addr       (clear_addr)
    );

    assign bus.clear_busy = clear_busy;

    always_comb begin
        bus.wr_ready = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bus.banka == BANK_WIDTH'(b) && clear_busy[b]) bus.wr_ready = 1'b0;
        end
    end

`ifdef MEM_CLEAR_READ_MASK_EN
    assign read_masked = clear_busy[bus.bankb];
`else
    assign read_masked = 1'b0;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  bank_we;
        logic [ADDR_WIDTH-1:0] bank_addr;
        logic [DATA_WIDTH-1:0] bank_wdata;

        // The clear engine owns a masked bank outright; wr_ready has already stalled the user.
        always_comb begin
            if (clear_busy[b]) begin
                bank_we    = 1'b1;
                bank_addr  = clear_addr;
                bank_wdata = DEFAULT_VALUE;
            end else begin
                bank_we    = bus.wea && bus.wr_ready && (bus.banka == BANK_WIDTH'(b));
                bank_addr  = bus.addra;
                bank_wdata = bus.dia;
            end
        end

        if (READ_DELAY == 0) begin : g_async
            mem_simple_dual_port_async_read #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_mem (
                .clk     (clk),
                .we      (bank_we),
                .wr_addr (bank_addr),
                .wr_data (bank_wdata),
                .rd_addr (bus.addrb),
                .rd_data (rd_data[b])
            );
        end else begin : g_sync
            mem_simple_dual_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_mem (
                .clk     (clk),
                .reset   (reset),
                .we      (bank_we),
                .wr_addr (bank_addr),
                .wr_data (bank_wdata),
                .re      (bus.reb),
                .rd_addr (bus.addrb),
                .rd_data (rd_data[b])
            );
        end
    end

    if (READ_DELAY == 0) begin : g_read_comb
        assign bus.dob       = read_masked ? DEFAULT_VALUE : rd_data[bus.bankb];
        assign bus.dob_valid = bus.reb;
    end else begin : g_read_pipe
        logic [BANK_WIDTH-1:0] sel_q;
        logic                  masked_q;
        logic                  valid_q;
        logic [DATA_WIDTH-1:0] stage0_data;

        // Bank select and mask flag travel with the RAM's own output register.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sel_q    <= '0;
                masked_q <= 1'b0;
                valid_q  <= 1'b0;
            end else begin
                valid_q <= bus.reb;
                if (bus.reb) begin
                    sel_q    <= bus.bankb;
                    masked_q <= read_masked;
                end
            end
        end

        assign stage0_data = masked_q ? DEFAULT_VALUE : rd_data[sel_q];

        if (READ_DELAY == 1) begin : g_one
            assign bus.dob       = stage0_data;
            assign bus.dob_valid = valid_q;
        end else begin : g_more
            logic [DATA_WIDTH-1:0] data_pipe  [1:READ_DELAY-1];
            logic                  valid_pipe [1:READ_DELAY-1];

            // Data stages advance only behind a valid word, so dob holds between reads.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 1; s < READ_DELAY; s++) begin
                        data_pipe[s]  <= '0;
                        valid_pipe[s] <= 1'b0;
                    end
                end else begin
                    valid_pipe[1] <= valid_q;
                    if (valid_q) data_pipe[1] <= stage0_data;
                    for (int s = 2; s < READ_DELAY; s++) begin
                        valid_pipe[s] <= valid_pipe[s-1];
                        if (valid_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
                    end
                end
            end

            assign bus.dob       = data_pipe[READ_DELAY-1];
            assign bus.dob_valid = valid_pipe[READ_DELAY-1];
        end
    end

endmodule

// File: tb/tb_mem_multi_bank_clear.sv
// Directed self-checking bench for mem_multi_bank_clear (default parameters, read latency 1).
module tb_mem_multi_bank_clear;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int NB = 4;
    localparam int AW = 4;
    localparam int BW = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   done_count = 0;

    mem_multi_bank_clear_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BANKS(NB)) bus ();

    mem_multi_bank_clear #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .NUM_BANKS     (NB),
        .OUTPUT_DELAY  (1),
        .DEFAULT_VALUE (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.clear_done_pulse === 1'b1) done_count++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [BW-1:0] bank, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.wea = 1'b1; bus.banka = bank; bus.addra = addr; bus.dia = data;
        @(negedge clk);
        bus.wea = 1'b0;
    endtask

    task automatic fill_bank(input int bank, input logic [DW-1:0] data);
        for (int a = 0; a < DEPTH; a++) write_word(BW'(bank), AW'(a), data);
    endtask

    task automatic read_check(input string tag, input logic [BW-1:0] bank, input logic [AW-1:0] addr,
                              input logic [DW-1:0] exp);
        bus.reb = 1'b1; bus.bankb = bank; bus.addrb = addr;
        @(negedge clk);
        bus.reb = 1'b0;
        check({tag, " data"}, 32'(bus.dob), 32'(exp));
    endtask

    task automatic start_clear(input logic [NB-1:0] mask);
        bus.clear_req = 1'b1; bus.clear_mask = mask;
        @(negedge clk);
        bus.clear_req = 1'b0; bus.clear_mask = '0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.clear_done_pulse !== 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, " done seen"}, 32'(bus.clear_done_pulse), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int dc;
        logic [DW-1:0] held;
        logic [DW-1:0] exp_mask_read;

        bus.clear_req = 1'b0; bus.clear_mask = '0;
        bus.wea = 1'b0; bus.banka = '0; bus.addra = '0; bus.dia = '0;
        bus.reb = 1'b0; bus.bankb = '0; bus.addrb = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst done", 32'(bus.clear_done_pulse), 32'd0);
        check("rst busy", 32'(bus.clear_busy), 32'd0);
        check("rst dob_valid", 32'(bus.dob_valid), 32'd0);
        check("rst dob", 32'(bus.dob), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst ready", 32'(bus.clear_ready), 32'd1);

        // Full clear
        for (int b = 0; b < NB; b++) fill_bank(b, 8'hA5);
        read_check("pre full b2a9", 2'd2, 4'd9, 8'hA5);
        check("read valid", 32'(bus.dob_valid), 32'd1);
        held = bus.dob;
        @(negedge clk);
        check("hold valid low", 32'(bus.dob_valid), 32'd0);
        check("hold dob", 32'(bus.dob), 32'(held));
        start_clear(4'b1111);
        check("full busy", 32'(bus.clear_busy), 32'hF);
        cnt = 0;
        while (bus.clear_ready !== 1'b1 && cnt < 40) begin
            check("full no early done", 32'(bus.clear_done_pulse), 32'd0);
            cnt++;
            @(negedge clk);
        end
        check("full ready low cycles", 32'(cnt), 32'd16);
        check("full done cycle 17", 32'(bus.clear_done_pulse), 32'd1);
        @(negedge clk);
        check("full done one cycle", 32'(bus.clear_done_pulse), 32'd0);
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++) read_check("full cleared", BW'(b), AW'(a), 8'h00);

        // Partial clear
        for (int b = 0; b < NB; b++) fill_bank(b, 8'h3C);
        start_clear(4'b0101);
        wait_done("partial");
        for (int b = 0; b < NB; b++) begin
            read_check("partial a0", BW'(b), 4'd0, (b % 2 == 0) ? 8'h00 : 8'h3C);
            read_check("partial a15", BW'(b), 4'd15, (b % 2 == 0) ? 8'h00 : 8'h3C);
        end

        // Read and write to the same address in one cycle return the old word
        bus.wea = 1'b1; bus.banka = 2'd3; bus.addra = 4'd3; bus.dia = 8'h11;
        bus.reb = 1'b1; bus.bankb = 2'd3; bus.addrb = 4'd3;
        @(negedge clk);
        bus.wea = 1'b0; bus.reb = 1'b0;
        check("rdw old data", 32'(bus.dob), 32'h3C);
        read_check("rdw new data", 2'd3, 4'd3, 8'h11);

        // Writes during a clear of bank 0
        start_clear(4'b0001);
        repeat (8) @(negedge clk);
        bus.wea = 1'b1; bus.banka = 2'd1; bus.addra = 4'd5; bus.dia = 8'h77;
        #1 check("wdc bank1 ready", 32'(bus.wr_ready), 32'd1);
        @(negedge clk);
        bus.banka = 2'd0;
        #1 check("wdc bank0 ready", 32'(bus.wr_ready), 32'd0);
        @(negedge clk);
        bus.wea = 1'b0;
        wait_done("wdc");
        read_check("wdc bank1 a5", 2'd1, 4'd5, 8'h77);
        read_check("wdc bank0 a5", 2'd0, 4'd5, 8'h00);

        // Reset in the middle of a clear, after addresses 0..7 are cleared
        fill_bank(0, 8'hA5);
        start_clear(4'b0001);
        repeat (8) @(negedge clk);
        check("mid busy before reset", 32'(bus.clear_busy), 32'h1);
        dc = done_count;
        reset = 1'b1;
        #1;
        check("mid rst busy", 32'(bus.clear_busy), 32'd0);
        check("mid rst done", 32'(bus.clear_done_pulse), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("mid no done pulse", 32'(done_count - dc), 32'd0);
        check("mid ready", 32'(bus.clear_ready), 32'd1);
        for (int a = 0; a < DEPTH; a++) read_check("mid data", 2'd0, AW'(a), (a < 8) ? 8'h00 : 8'hA5);

        // Read of a bank while it is being cleared
`ifdef MEM_CLEAR_READ_MASK_EN
        exp_mask_read = 8'h00;
`else
        exp_mask_read = 8'h5A;
`endif
        write_word(2'd0, 4'd15, 8'h5A);
        start_clear(4'b0001);
        read_check("read mask b0a15", 2'd0, 4'd15, exp_mask_read);
        check("read mask valid", 32'(bus.dob_valid), 32'd1);
        wait_done("read mask");

        // Zero mask
        start_clear(4'b0000);
        check("zero done next cycle", 32'(bus.clear_done_pulse), 32'd1);
        check("zero ready", 32'(bus.clear_ready), 32'd1);
        @(negedge clk);
        check("zero done one cycle", 32'(bus.clear_done_pulse), 32'd0);

        // Requests during CLEAR are ignored
        dc = done_count;
        start_clear(4'b1111);
        repeat (3) @(negedge clk);
        start_clear(4'b0010);
        check("b2b mask kept", 32'(bus.clear_busy), 32'hF);
        start_clear(4'b0000);
        wait_done("b2b");
        repeat (20) @(negedge clk);
        check("b2b one done", 32'(done_count - dc), 32'd1);
        check("b2b ready", 32'(bus.clear_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
